turf_udp_tx_arbiter: RTL and testbench
======================================

# turf_udp_tx_arbiter

Round-robin arbiter sharing the single UDP transmit path (header stream plus payload stream) of the TURF UDP core among `NUM_PORTS` requesters, e.g. event readout, control replies and housekeeping. Each requester presents a UDP header beat followed by a 64-bit payload stream. The arbiter grants one requester at a time and holds the grant from header acceptance through the payload `tlast` beat, so packets are never interleaved. It sits directly upstream of the UDP core's `s_udphdr_*` / `s_udpdata_*` inputs.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `PORT_BITS`, `$clog2(NUM_PORTS)`: grant index width (derived).
- `clk` in 1: system clock; same as the UDP core's `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_udphdr_tdata` in `NUM_PORTS*64`: per-port header. Fields: `[32 +: 32]` dst IP, `[16 +: 16]` dst port, `[0 +: 16]` UDP length.
- `s_udphdr_tuser` in `NUM_PORTS*16`: per-port UDP source port.
- `s_udphdr_tvalid` in `NUM_PORTS`: header valid.
- `s_udphdr_tready` out `NUM_PORTS`: header ready.
- `s_udpdata_tdata` in `NUM_PORTS*64`: payload data.
- `s_udpdata_tkeep` in `NUM_PORTS*8`: payload byte enables.
- `s_udpdata_tlast` in `NUM_PORTS`: payload last beat.
- `s_udpdata_tvalid` in `NUM_PORTS`: payload valid.
- `s_udpdata_tready` out `NUM_PORTS`: payload ready.
- `m_udphdr_tdata` out 64: header to UDP core.
- `m_udphdr_tuser` out 16: source port to UDP core.
- `m_udphdr_tvalid` out 1: header valid to UDP core.
- `m_udphdr_tready` in 1: header ready from UDP core.
- `m_udpdata_tdata` out 64: payload to UDP core.
- `m_udpdata_tkeep` out 8: payload byte enables to UDP core.
- `m_udpdata_tlast` out 1: payload last beat to UDP core.
- `m_udpdata_tvalid` out 1: payload valid to UDP core.
- `m_udpdata_tready` in 1: payload ready from UDP core.
- `active_port` out `PORT_BITS`: current grant index.
- `busy` out 1: high in HDR or DATA state.

## Operation
- FSM states: IDLE, HDR, DATA. Registers: `state`, `grant`, `last_grant`.
- IDLE: if any `s_udphdr_tvalid` is high, pick the first set bit searching from `last_grant+1` and wrapping modulo `NUM_PORTS`. Register it into `grant`, then go to HDR. If none is set, stay in IDLE.
- HDR: `m_udphdr_*` = `s_udphdr_*[grant]`. `s_udphdr_tready[grant]` = `m_udphdr_tready`. On handshake, go to DATA. All data readies are low in HDR.
- DATA: `m_udpdata_*` = `s_udpdata_*[grant]`. `s_udpdata_tready[grant]` = `m_udpdata_tready`. On a handshake with `tlast` high, set `last_grant <= grant` and go to IDLE.
- Ungranted ports: `tready` is held low on both streams.
- Outputs are a pure mux off the registered `grant` and `state`. There is no combinational path from any `s_*_tvalid` to any `s_*_tready`.
- In IDLE, all `m_*_tvalid` are 0. Data fields are don't-care.
- Payload length is not checked against the UDP length field. Every packet carries at least one data beat.
- A requester that drops header `tvalid` before grant simply loses that arbitration round.
- A requester may present payload before its header is accepted. Those beats stall until DATA.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `last_grant`=`NUM_PORTS-1` (so port 0 has first priority).
- Reset values of outputs: all `tready` low, all `m_*_tvalid` low, `busy`=0, `active_port`=0.
- Latency: header `tvalid` sampled in IDLE at cycle N gives `m_udphdr_tvalid` high at cycle N+1.
- Throughput: one IDLE bubble cycle between packets. Payload flows at 1 beat/clk while the granted source and the UDP core both keep valid and ready high.
- Simultaneous requests: the round-robin pointer guarantees each requesting port is served within `NUM_PORTS` packets.
- Reset mid-packet: the FSM drops to IDLE immediately and all valids deassert. A truncated packet downstream is the sources' responsibility.

## Configuration
- `TURF_UDP_ARB_STATS_EN` defined: adds output `pkt_count` (`NUM_PORTS*32`). It holds one free-running packet counter per port.
  - A port's counter increments on that port's payload `tlast` handshake.
  - Counters wrap at 2^32 and reset to 0.
- Macro undefined: the port and the counters are absent.

## Structure
- Shared package `turf_udp_pkg`: header field offsets (IP=32, port=16, length=0), widths 64/16/8, and the FSM state encoding.
- Sub-module `turf_rr_pick`: combinational round-robin first-set search over `NUM_PORTS` request bits starting after `last_grant`. It returns the index and a found flag.

## Test plan
- Reset release, no requests -> all readies/valids 0, `busy`=0, `active_port`=0 for 20 clks.
- Port 2 sends header {10.68.65.1, port 0x1234, len 24} and 2 payload beats (last `tkeep`=0xFF) -> header appears 1 clk after IDLE sample; `m_udpdata` carries 2 beats with `tlast` on beat 2; FSM returns to IDLE.
- All 4 ports request simultaneously after reset, 3 beats each -> serve order 0,1,2,3; no interleaving; 3 IDLE bubbles total.
- Port 1 holding continuous requests while port 3 requests once -> port 3 is served after at most one port-1 packet.
- Random `m_udpdata_tready` and `m_udphdr_tready` backpressure (50%) on 100 packets -> byte-exact payload and header match per port; ungranted readies never high.
- `rst_n` pulsed low mid-DATA on port 0 -> outputs at reset values within the same cycle; next packet from port 1 passes cleanly. With `TURF_UDP_ARB_STATS_EN`: `pkt_count` returns to 0, then port 1's counter reads 1.

Source files
------------

// File: rtl/turf_udp_pkg.sv
// Shared definitions for the TURF UDP transmit path.
//   - Header beat field layout (dst IP / dst port / UDP length).
//   - Stream widths for header, source port, payload and byte enables.
//   - State encoding for the transmit arbiter FSM.
package turf_udp_pkg;

    localparam int HDR_W   = 64;
    localparam int SPORT_W = 16;
    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;

    localparam int HDR_IP_OFF   = 32;
    localparam int HDR_IP_W     = 32;
    localparam int HDR_PORT_OFF = 16;
    localparam int HDR_PORT_W   = 16;
    localparam int HDR_LEN_OFF  = 0;
    localparam int HDR_LEN_W    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/turf_rr_pick.sv
// Round-robin first-set search.
// Scans req_i starting at last_grant_i+1 and wrapping modulo NUM_PORTS;
// the previous winner is examined last.
//   req_i        : request bits, one per port
//   last_grant_i : index of the most recently served port
//   idx_o        : index of the selected port (0 when nothing requested)
//   found_o      : at least one request bit set
module turf_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_BITS-1:0] last_grant_i,
    output logic [PORT_BITS-1:0] idx_o,
    output logic                 found_o
);

    logic [PORT_BITS-1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PORT_BITS'((int'(last_grant_i) + i) % NUM_PORTS);
            if (!found_o && req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turf_udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP core transmit path (header stream +
// 64-bit payload stream) among NUM_PORTS requesters. A grant is held from
// header acceptance through the payload tlast beat, so packets never
// interleave. Outputs are a pure mux of registered state/grant; no source
// tvalid reaches any source tready combinationally.
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   s_udphdr_*  (per port)     : header beat in (tdata, tuser=src port, tvalid/tready)
//   s_udpdata_* (per port)     : payload in (tdata, tkeep, tlast, tvalid/tready)
//   m_udphdr_*                 : header beat to UDP core
//   m_udpdata_*                : payload to UDP core
//   active_port                : current grant index
//   busy                       : packet in flight (HDR or DATA)
//   pkt_count                  : per-port 32-bit packet counters, only when
//                                TURF_UDP_ARB_STATS_EN is defined
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; pick next requester round-robin after last_grant
// HDR     | granted port's header routed to core, waiting for handshake
// DATA    | granted port's payload routed to core until tlast handshake
module turf_udp_tx_arbiter
    import turf_udp_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_PORTS*HDR_W-1:0]    s_udphdr_tdata,
    input  logic [NUM_PORTS*SPORT_W-1:0]  s_udphdr_tuser,
    input  logic [NUM_PORTS-1:0]          s_udphdr_tvalid,
    output logic [NUM_PORTS-1:0]          s_udphdr_tready,

    input  logic [NUM_PORTS*DATA_W-1:0]   s_udpdata_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]   s_udpdata_tkeep,
    input  logic [NUM_PORTS-1:0]          s_udpdata_tlast,
    input  logic [NUM_PORTS-1:0]          s_udpdata_tvalid,
    output logic [NUM_PORTS-1:0]          s_udpdata_tready,

    output logic [HDR_W-1:0]              m_udphdr_tdata,
    output logic [SPORT_W-1:0]            m_udphdr_tuser,
    output logic                          m_udphdr_tvalid,
    input  logic                          m_udphdr_tready,

    output logic [DATA_W-1:0]             m_udpdata_tdata,
    output logic [KEEP_W-1:0]             m_udpdata_tkeep,
    output logic                          m_udpdata_tlast,
    output logic                          m_udpdata_tvalid,
    input  logic                          m_udpdata_tready,

    output logic [PORT_BITS-1:0]          active_port,
    output logic                          busy
`ifdef TURF_UDP_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]       pkt_count
`endif
);

    logic [1:0]           state_q, state_d;
    logic [PORT_BITS-1:0] grant_q, grant_d;
    logic [PORT_BITS-1:0] last_grant_q, last_grant_d;

    logic [PORT_BITS-1:0] pick_idx;
    logic                 pick_found;
    logic                 hdr_hs;
    logic                 last_hs;

    logic [HDR_W-1:0]   hdr_data  [NUM_PORTS];
    logic [SPORT_W-1:0] hdr_user  [NUM_PORTS];
    logic [DATA_W-1:0]  dat_data  [NUM_PORTS];
    logic [KEEP_W-1:0]  dat_keep  [NUM_PORTS];

    genvar g;
    for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign hdr_data[g] = s_udphdr_tdata[g*HDR_W +: HDR_W];
        assign hdr_user[g] = s_udphdr_tuser[g*SPORT_W +: SPORT_W];
        assign dat_data[g] = s_udpdata_tdata[g*DATA_W +: DATA_W];
        assign dat_keep[g] = s_udpdata_tkeep[g*KEEP_W +: KEEP_W];
    end

    turf_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_pick (
        .req_i        (s_udphdr_tvalid),
        .last_grant_i (last_grant_q),
        .idx_o        (pick_idx),
        .found_o      (pick_found)
    );

    // Data fields follow the grant unconditionally; only the valids are
    // qualified by state, which keeps the mux shallow.
    assign m_udphdr_tdata   = hdr_data[grant_q];
    assign m_udphdr_tuser   = hdr_user[grant_q];
    assign m_udphdr_tvalid  = (state_q == ST_HDR) && s_udphdr_tvalid[grant_q];
    assign m_udpdata_tdata  = dat_data[grant_q];
    assign m_udpdata_tkeep  = dat_keep[grant_q];
    assign m_udpdata_tlast  = s_udpdata_tlast[grant_q];
    assign m_udpdata_tvalid = (state_q == ST_DATA) && s_udpdata_tvalid[grant_q];

    assign active_port = grant_q;
    assign busy        = (state_q != ST_IDLE);

    assign hdr_hs  = m_udphdr_tvalid && m_udphdr_tready;
    assign last_hs = m_udpdata_tvalid && m_udpdata_tready && m_udpdata_tlast;

    always_comb begin
        s_udphdr_tready  = '0;
        s_udpdata_tready = '0;
        if (state_q == ST_HDR)  s_udphdr_tready[grant_q]  = m_udphdr_tready;
        if (state_q == ST_DATA) s_udpdata_tready[grant_q] = m_udpdata_tready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_hs) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (last_hs) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to the highest index so port 0 wins the first round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef TURF_UDP_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) pkt_cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (last_hs && (grant_q == PORT_BITS'(p))) pkt_cnt_q[p] <= pkt_cnt_q[p] + 32'd1;
            end
        end
    end

    for (g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign pkt_count[g*32 +: 32] = pkt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// Directed bench for turf_udp_tx_arbiter (NUM_PORTS=4): idle after reset,
// single packet timing, simultaneous requests, round-robin fairness,
// randomised backpressure with per-port payload integrity, and reset in
// the middle of a packet.
`timescale 1ns/1ps
module tb_turf_udp_tx_arbiter;
    import turf_udp_pkg::*;

    localparam int NP = 4;
    localparam int PB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NP*HDR_W-1:0]   s_udphdr_tdata;
    logic [NP*SPORT_W-1:0] s_udphdr_tuser;
    logic [NP-1:0]         s_udphdr_tvalid;
    logic [NP-1:0]         s_udphdr_tready;
    logic [NP*DATA_W-1:0]  s_udpdata_tdata;
    logic [NP*KEEP_W-1:0]  s_udpdata_tkeep;
    logic [NP-1:0]         s_udpdata_tlast;
    logic [NP-1:0]         s_udpdata_tvalid;
    logic [NP-1:0]         s_udpdata_tready;
    logic [HDR_W-1:0]      m_udphdr_tdata;
    logic [SPORT_W-1:0]    m_udphdr_tuser;
    logic                  m_udphdr_tvalid;
    logic                  m_udphdr_tready;
    logic [DATA_W-1:0]     m_udpdata_tdata;
    logic [KEEP_W-1:0]     m_udpdata_tkeep;
    logic                  m_udpdata_tlast;
    logic                  m_udpdata_tvalid;
    logic                  m_udpdata_tready;
    logic [PB-1:0]         active_port;
    logic                  busy;
`ifdef TURF_UDP_ARB_STATS_EN
    logic [NP*32-1:0]      pkt_count;
`endif

    always #5 clk = ~clk;

    turf_udp_tx_arbiter #(.NUM_PORTS(NP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_udphdr_tdata   (s_udphdr_tdata),
        .s_udphdr_tuser   (s_udphdr_tuser),
        .s_udphdr_tvalid  (s_udphdr_tvalid),
        .s_udphdr_tready  (s_udphdr_tready),
        .s_udpdata_tdata  (s_udpdata_tdata),
        .s_udpdata_tkeep  (s_udpdata_tkeep),
        .s_udpdata_tlast  (s_udpdata_tlast),
        .s_udpdata_tvalid (s_udpdata_tvalid),
        .s_udpdata_tready (s_udpdata_tready),
        .m_udphdr_tdata   (m_udphdr_tdata),
        .m_udphdr_tuser   (m_udphdr_tuser),
        .m_udphdr_tvalid  (m_udphdr_tvalid),
        .m_udphdr_tready  (m_udphdr_tready),
        .m_udpdata_tdata  (m_udpdata_tdata),
        .m_udpdata_tkeep  (m_udpdata_tkeep),
        .m_udpdata_tlast  (m_udpdata_tlast),
        .m_udpdata_tvalid (m_udpdata_tvalid),
        .m_udpdata_tready (m_udpdata_tready),
        .active_port      (active_port),
        .busy             (busy)
`ifdef TURF_UDP_ARB_STATS_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int nb_fix = 2;
    int order[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbeats(input int p, input int k);
        return (nb_fix != 0) ? nb_fix : 1 + ((p + k) % 4);
    endfunction

    function automatic logic [63:0] exp_hdr(input int p, input int k);
        logic [63:0] h;
        h = '0;
        h[HDR_IP_OFF +: HDR_IP_W]     = 32'h0A44_4100 + 32'(p);
        h[HDR_PORT_OFF +: HDR_PORT_W] = 16'h1000 + 16'(k);
        h[HDR_LEN_OFF +: HDR_LEN_W]   = 16'(8 + 8 * nbeats(p, k));
        return h;
    endfunction

    function automatic logic [15:0] exp_user(input int p);
        return 16'hC000 + 16'(p);
    endfunction

    function automatic logic [63:0] exp_dat(input int p, input int k, input int b);
        return {8'hA0 + 8'(p), 24'(k), 16'hD5D5, 16'(b)};
    endfunction

    function automatic logic [7:0] exp_keep(input int p, input int k, input int b);
        return (b == nbeats(p, k) - 1) ? (8'hFF >> ((p + k) % 8)) : 8'hFF;
    endfunction

    task automatic set_hdr(input int p, input bit v, input logic [63:0] d, input logic [15:0] u);
        s_udphdr_tvalid[p]          = v;
        s_udphdr_tdata[p*64 +: 64]  = d;
        s_udphdr_tuser[p*16 +: 16]  = u;
    endtask

    task automatic set_dat(input int p, input bit v, input logic [63:0] d, input logic [7:0] k, input bit l);
        s_udpdata_tvalid[p]         = v;
        s_udpdata_tdata[p*64 +: 64] = d;
        s_udpdata_tkeep[p*8 +: 8]   = k;
        s_udpdata_tlast[p]          = l;
    endtask

    task automatic clear_inputs();
        s_udphdr_tdata   = '0;
        s_udphdr_tuser   = '0;
        s_udphdr_tvalid  = '0;
        s_udpdata_tdata  = '0;
        s_udpdata_tkeep  = '0;
        s_udpdata_tlast  = '0;
        s_udpdata_tvalid = '0;
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sources stream packets per port; a separate per-port receive
    // scoreboard checks every header/beat seen at the core side.
    task automatic run_traffic(input string tag, input int n0, input int n1, input int n2,
                               input int n3, input int nbf, input bit bp, output int idle_o);
        int  np [NP];
        int  src_h [NP];
        int  src_d [NP];
        int  src_b [NP];
        int  rx_p [NP];
        int  rx_b [NP];
        int  cur;
        int  a;
        bit  in_pkt;
        bit  started;
        bit  done;
        logic [NP-1:0] oh;
        np      = '{n0, n1, n2, n3};
        src_h   = '{0, 0, 0, 0};
        src_d   = '{0, 0, 0, 0};
        src_b   = '{0, 0, 0, 0};
        rx_p    = '{0, 0, 0, 0};
        rx_b    = '{0, 0, 0, 0};
        nb_fix  = nbf;
        cur     = 0;
        in_pkt  = 0;
        started = 0;
        done    = 0;
        idle_o  = 0;
        order.delete();
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                set_hdr(p, src_h[p] < np[p], exp_hdr(p, src_h[p]), exp_user(p));
                set_dat(p, src_d[p] < np[p], exp_dat(p, src_d[p], src_b[p]),
                        exp_keep(p, src_d[p], src_b[p]), src_b[p] == nbeats(p, src_d[p]) - 1);
            end
            m_udphdr_tready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_udpdata_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            oh = '0;
            oh[active_port] = 1'b1;
            check({tag, "_ungranted_rdy"}, {s_udphdr_tready & ~oh, s_udpdata_tready & ~oh}, 128'd0);
            if (m_udphdr_tvalid && m_udphdr_tready) begin
                a = int'(active_port);
                check({tag, "_hdr_between"}, in_pkt, 0);
                check({tag, "_hdr_data"}, m_udphdr_tdata, exp_hdr(a, rx_p[a]));
                check({tag, "_hdr_user"}, m_udphdr_tuser, exp_user(a));
                cur     = a;
                in_pkt  = 1;
                started = 1;
                order.push_back(a);
            end
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                check({tag, "_dat_inpkt"}, in_pkt, 1);
                check({tag, "_dat_port"}, active_port, cur);
                check({tag, "_dat_data"}, m_udpdata_tdata, exp_dat(cur, rx_p[cur], rx_b[cur]));
                check({tag, "_dat_keep"}, m_udpdata_tkeep, exp_keep(cur, rx_p[cur], rx_b[cur]));
                check({tag, "_dat_last"}, m_udpdata_tlast, rx_b[cur] == nbeats(cur, rx_p[cur]) - 1);
                if (rx_b[cur] == nbeats(cur, rx_p[cur]) - 1) begin
                    rx_b[cur] = 0;
                    rx_p[cur]++;
                    in_pkt = 0;
                end else begin
                    rx_b[cur]++;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (s_udphdr_tvalid[p] && s_udphdr_tready[p]) src_h[p]++;
                if (s_udpdata_tvalid[p] && s_udpdata_tready[p]) begin
                    if (s_udpdata_tlast[p]) begin
                        src_b[p] = 0;
                        src_d[p]++;
                    end else begin
                        src_b[p]++;
                    end
                end
            end
            done = 1;
            for (int p = 0; p < NP; p++) if (rx_p[p] != np[p]) done = 0;
            if (started && !busy && !done) idle_o++;
        end
        check({tag, "_completed"}, done, 1);
        for (int p = 0; p < NP; p++) check({tag, "_rx_pkts"}, rx_p[p], np[p]);
        @(negedge clk);
        clear_inputs();
    endtask

    int idle_cnt;
    int exp_ord4[6];
    logic [63:0] h2;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("idle_rdy", {s_udphdr_tready, s_udpdata_tready}, 128'd0);
            check("idle_vld_busy", {m_udphdr_tvalid, m_udpdata_tvalid, busy}, 128'd0);
            check("idle_port", active_port, 0);
        end

        // Single packet on port 2
        apply_reset();
        h2 = {32'h0A44_4101, 16'h1234, 16'd24};
        @(negedge clk);
        set_hdr(2, 1, h2, 16'hBEEF);
        set_dat(2, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        #1;
        check("t2_idle_hv", m_udphdr_tvalid, 0);
        check("t2_idle_rdy", {s_udphdr_tready, s_udpdata_tready}, 128'd0);
        @(negedge clk);
        #1;
        check("t2_hdr_valid", m_udphdr_tvalid, 1);
        check("t2_hdr_data", m_udphdr_tdata, h2);
        check("t2_hdr_user", m_udphdr_tuser, 16'hBEEF);
        check("t2_hdr_port", active_port, 2);
        check("t2_hdr_busy", busy, 1);
        check("t2_hdr_hrdy", s_udphdr_tready, 4'b0100);
        check("t2_hdr_drdy", s_udpdata_tready, 4'b0000);
        check("t2_hdr_dvld", m_udpdata_tvalid, 0);
        @(negedge clk);
        set_hdr(2, 0, 64'd0, 16'd0);
        #1;
        check("t2_b0_valid", m_udpdata_tvalid, 1);
        check("t2_b0_data", m_udpdata_tdata, 64'h0123_4567_89AB_CDEF);
        check("t2_b0_last", m_udpdata_tlast, 0);
        check("t2_b0_drdy", s_udpdata_tready, 4'b0100);
        check("t2_b0_hvld", {m_udphdr_tvalid, s_udphdr_tready}, 128'd0);
        @(negedge clk);
        set_dat(2, 1, 64'hFEDC_BA98_7654_3210, 8'hFF, 1);
        #1;
        check("t2_b1_data", m_udpdata_tdata, 64'hFEDC_BA98_7654_3210);
        check("t2_b1_last", m_udpdata_tlast, 1);
        check("t2_b1_keep", m_udpdata_tkeep, 8'hFF);
        @(negedge clk);
        set_dat(2, 0, 64'd0, 8'h00, 0);
        #1;
        check("t2_end_idle", {m_udphdr_tvalid, m_udpdata_tvalid, busy}, 128'd0);

        // All four ports at once, three beats each
        apply_reset();
        run_traffic("t3", 1, 1, 1, 1, 3, 0, idle_cnt);
        check("t3_order_len", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("t3_order", order[i], i);
        check("t3_idle_bubbles", idle_cnt, 3);

        // Port 1 streaming, port 3 once
        apply_reset();
        exp_ord4 = '{1, 3, 1, 1, 1, 1};
        run_traffic("t4", 0, 5, 0, 1, 2, 0, idle_cnt);
        check("t4_order_len", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) check("t4_order", order[i], exp_ord4[i]);

        // Backpressure, 100 packets
        apply_reset();
        run_traffic("t5", 25, 25, 25, 25, 0, 1, idle_cnt);

        // Reset in the middle of a port-0 packet
        @(negedge clk);
        nb_fix = 3;
        set_hdr(0, 1, exp_hdr(0, 0), exp_user(0));
        set_dat(0, 1, 64'h1111_2222_3333_4444, 8'hFF, 0);
        @(negedge clk);
        #1;
        check("t6_hdr_valid", m_udphdr_tvalid, 1);
        check("t6_hdr_port", active_port, 0);
        @(negedge clk);
        set_hdr(0, 0, 64'd0, 16'd0);
        #1;
        check("t6_in_data", m_udpdata_tvalid, 1);
`ifdef TURF_UDP_ARB_STATS_EN
        check("t6_cnt_before", pkt_count, {4{32'd25}});
`endif
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld_busy", {m_udphdr_tvalid, m_udpdata_tvalid, busy}, 128'd0);
        check("t6_rst_rdy", {s_udphdr_tready, s_udpdata_tready}, 128'd0);
        check("t6_rst_port", active_port, 0);
`ifdef TURF_UDP_ARB_STATS_EN
        check("t6_cnt_rst", pkt_count, 128'd0);
`endif
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        run_traffic("t6", 0, 1, 0, 0, 2, 0, idle_cnt);
        check("t6_order_len", order.size(), 1);
        if (order.size() > 0) check("t6_order", order[0], 1);
`ifdef TURF_UDP_ARB_STATS_EN
        check("t6_cnt_after", pkt_count, {32'd0, 32'd0, 32'd1, 32'd0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
